i2s_rx: RTL and testbench
=========================

Name: i2s_rx

Overview:
- I2S receive deserializer for the codec ADC path (ac_adc_sdata).
- The FPGA is I2S master: the existing transmit controller drives BCLK/LRCLK. This block observes those pins and captures left/right 24-bit samples MSB-first.
- It presents the samples as a parallel stereo frame with a one-cycle valid strobe for the audio and effects logic.
- It is the receive counterpart of the I2S transmitter and runs in the system clk domain.

Parameters:
- DATA_WIDTH, 24, captured bits per channel, MSB-first.
- SLOT_BITS, 32, nominal BCLK periods per LRCLK half-frame; also the slot-overrun limit.
- SYNC_STAGES, 2, synchronizer flops on bclk, lrclk and sdata. All three use equal depth so they stay aligned.

Ports:
- clk  in  1  system clock; the only clock domain.
- rst  in  1  synchronous reset, active-high.
- en_i  in  1  receive enable; low forces HUNT and suppresses all outputs except held data.
- bclk_i  in  1  serial bit clock, same net as ac_bclk.
- lrclk_i  in  1  word select, same net as ac_lrclk; 0 = left, 1 = right.
- sdata_i  in  1  serial data from ac_adc_sdata.
- d_l_o  out  DATA_WIDTH  last complete left sample.
- d_r_o  out  DATA_WIDTH  last complete right sample.
- valid_o  out  1  one-clk pulse when d_l_o and d_r_o update together.
- locked_o  out  1  high after one clean stereo frame; low in HUNT.
- sync_err_o  out  1  one-clk pulse on a short or overlong slot.

Behaviour:
- Reset (rst=1 at a clk edge):
  - d_l_o=0, d_r_o=0, valid_o=0, locked_o=0, sync_err_o=0.
  - State=HUNT, synchronizers cleared, left_seen=0.
- Sampling:
  - bclk, lrclk and sdata each pass through SYNC_STAGES flops.
  - A bit event occurs in the cycle the synchronized bclk is 1 and was 0 in the previous cycle.
  - All state updates below happen only on bit events. No other cycle changes state.
- LR change: lrclk sampled at a bit event differs from lrclk sampled at the previous bit event.
  - The sdata bit in that event belongs to the previous slot and is discarded (I2S one-bit delay).
  - The next event carries the MSB.
- States:
  - HUNT: wait for an LR change, then go to SHIFT with ch=new lrclk, bit_cnt=0, slot_cnt=1.
  - SHIFT: each event shifts sdata into the LSB of the shift register, bit_cnt++, slot_cnt++.
    - When bit_cnt reaches DATA_WIDTH, commit the word to the hold register of ch and go to PAD.
    - An LR change before completion is a short slot: discard the partial word, pulse sync_err_o, clear left_seen, and restart SHIFT for the new ch.
  - PAD: ignore data, slot_cnt++.
    - On an LR change, go to SHIFT for the new ch.
    - If slot_cnt exceeds SLOT_BITS without an LR change: pulse sync_err_o, set locked_o=0, go to HUNT.
- Frame assembly:
  - Left commit: hold_l <= word, left_seen=1.
  - Right commit with left_seen=1:
    - d_l_o <= hold_l and d_r_o <= word in the same clk.
    - valid_o=1 for exactly that one cycle; locked_o <= 1; left_seen=0.
  - Right commit with left_seen=0 (first slot after lock/HUNT): discard, no valid.
- Latency: valid_o rises 1 clk after the bit event carrying the right LSB, i.e. SYNC_STAGES+2 clk after the raw bclk rise.
- Simultaneous events: an LR change in the same event as a commit cannot occur when DATA_WIDTH < SLOT_BITS. If DATA_WIDTH == SLOT_BITS, the commit takes priority, then SHIFT starts for the new ch.
- en_i=0:
  - Same as HUNT entry: locked_o=0, left_seen=0, no valid or sync_err pulses.
  - d_l_o and d_r_o hold their values.
- rst mid-frame: immediate return to the reset state. The partial word is lost and no valid is emitted.
- Widths: slot_cnt is clog2(SLOT_BITS+2) bits and saturates. bit_cnt is clog2(DATA_WIDTH+1) bits.

Decomposition:
- Shared package audio_pkg:
  - DATA_WIDTH/SLOT_BITS defaults.
  - State enum {HUNT, SHIFT, PAD}.
  - Channel constants CH_L=0, CH_R=1.
- Sub-module sync_edge: SYNC_STAGES synchronizer plus rising-edge detect.
  - Instantiated for bclk (with edge output).
  - Reused without edge output for lrclk and sdata.

Test Plan:
- Reset then 3 standard frames (BCLK = clk/8, 32 bits/slot) with L=0xA5F00F, R=0x123456 -> first valid after frame 2. Each valid gives d_l_o=0xA5F00F, d_r_o=0x123456; locked_o=1; no sync_err.
- Sample alternating L=0x800000 and R=0x000001, then L=0x7FFFFF and R=0xFFFFFF -> MSB/LSB order exact; valid_o exactly 1 clk wide, once per frame.
- Left slot shortened to 10 BCLKs -> sync_err_o pulses once, no valid for that frame. The next full frame gives valid with correct data.
- lrclk held constant for 40 BCLKs -> sync_err_o pulses, locked_o=0. Relock after the next clean L+R pair.
- Assert rst at bit 12 of the right slot -> outputs 0 next clk, no valid for that frame. Normal capture resumes after 2 frames.
- en_i=0 for 2 frames -> no valid_o, locked_o=0, d_l_o/d_r_o hold their previous values. Raise en_i -> valid returns within 2 frames.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants and state encoding for the codec audio receive path.
package audio_pkg;

  localparam int unsigned DATA_WIDTH_DEF  = 24;
  localparam int unsigned SLOT_BITS_DEF   = 32;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    SHIFT = 2'd1,
    PAD   = 2'd2
  } rx_state_e;

  localparam logic CH_L = 1'b0;
  localparam logic CH_R = 1'b1;

endpackage

// File: rtl/i2s_rx_sync_edge.sv
// Multi-flop synchronizer with an optional registered rising-edge strobe.
// Every instance has the same total depth, so the bclk, lrclk and sdata paths stay aligned.
module sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter bit          EDGE_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  logic [STAGES-1:0] r_sync;
  logic              r_q;
  logic              r_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_q    <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync[0] <= d_i;
      for (int unsigned i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_q    <= r_sync[STAGES-1];
      r_rise <= EDGE_EN && r_sync[STAGES-1] && !r_q;
    end
  end

  assign q_o    = r_q;
  assign rise_o = r_rise;

endmodule

// File: rtl/i2s_rx.sv
// I2S slave-side receiver: observes BCLK/LRCLK driven by the transmit controller and
// deserializes MSB-first left/right words into a parallel stereo frame with a valid strobe.
module i2s_rx
  import audio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned SLOT_BITS   = SLOT_BITS_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  bclk_i,
  input  logic                  lrclk_i,
  input  logic                  sdata_i,
  output logic [DATA_WIDTH-1:0] d_l_o,
  output logic [DATA_WIDTH-1:0] d_r_o,
  output logic                  valid_o,
  output logic                  locked_o,
  output logic                  sync_err_o
);

  localparam int unsigned SLOT_CNT_W = $clog2(SLOT_BITS + 2);
  localparam int unsigned BIT_CNT_W  = $clog2(DATA_WIDTH + 1);

  rx_state_e               r_state;
  logic                    r_ch;
  logic [BIT_CNT_W-1:0]    r_bit_cnt;
  logic [SLOT_CNT_W-1:0]   r_slot_cnt;
  logic [DATA_WIDTH-2:0]   r_shift;
  logic [DATA_WIDTH-1:0]   r_hold_l;
  logic                    r_left_seen;
  logic                    r_lr_prev;
  logic                    r_lr_vld;

  logic                    w_bit_evt;
  logic                    w_lr;
  logic                    w_sd;
  logic                    w_bclk_q_unused;
  logic                    w_lr_rise_unused;
  logic                    w_sd_rise_unused;
  logic                    w_lr_chg;
  logic                    w_last_bit;
  logic [DATA_WIDTH-1:0]   w_word;
  logic [SLOT_CNT_W-1:0]   w_slot_inc;

  sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_bclk (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bclk_i),
    .q_o    (w_bclk_q_unused),
    .rise_o (w_bit_evt)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_lrclk (
    .clk    (clk),
    .rst    (rst),
    .d_i    (lrclk_i),
    .q_o    (w_lr),
    .rise_o (w_lr_rise_unused)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_sdata (
    .clk    (clk),
    .rst    (rst),
    .d_i    (sdata_i),
    .q_o    (w_sd),
    .rise_o (w_sd_rise_unused)
  );

  // No LR change can be declared until one lrclk sample exists after reset.
  assign w_lr_chg   = r_lr_vld && (w_lr != r_lr_prev);
  assign w_last_bit = (r_bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1));
  assign w_word     = {r_shift, w_sd};
  assign w_slot_inc = (r_slot_cnt == {SLOT_CNT_W{1'b1}}) ? r_slot_cnt
                                                         : r_slot_cnt + SLOT_CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= HUNT;
      r_ch        <= CH_L;
      r_bit_cnt   <= '0;
      r_slot_cnt  <= '0;
      r_shift     <= '0;
      r_hold_l    <= '0;
      r_left_seen <= 1'b0;
      r_lr_prev   <= 1'b0;
      r_lr_vld    <= 1'b0;
      d_l_o       <= '0;
      d_r_o       <= '0;
      valid_o     <= 1'b0;
      locked_o    <= 1'b0;
      sync_err_o  <= 1'b0;
    end else begin
      valid_o    <= 1'b0;
      sync_err_o <= 1'b0;
      if (w_bit_evt) begin
        r_lr_prev <= w_lr;
        r_lr_vld  <= 1'b1;
      end
      if (!en_i) begin
        r_state     <= HUNT;
        r_left_seen <= 1'b0;
        locked_o    <= 1'b0;
      end else if (w_bit_evt) begin
        case (r_state)
          HUNT: begin
            if (w_lr_chg) begin
              r_ch       <= w_lr;
              r_bit_cnt  <= '0;
              r_slot_cnt <= SLOT_CNT_W'(1);
              r_state    <= SHIFT;
            end
          end
          SHIFT: begin
            // A commit coinciding with an LR change only exists when the word fills the slot.
            if (w_last_bit && (!w_lr_chg || DATA_WIDTH == SLOT_BITS)) begin
              if (r_ch == CH_L) begin
                r_hold_l    <= w_word;
                r_left_seen <= 1'b1;
              end else if (r_left_seen) begin
                d_l_o       <= r_hold_l;
                d_r_o       <= w_word;
                valid_o     <= 1'b1;
                locked_o    <= 1'b1;
                r_left_seen <= 1'b0;
              end
              r_slot_cnt <= w_slot_inc;
              r_state    <= PAD;
              if (w_lr_chg) begin
                r_ch       <= w_lr;
                r_bit_cnt  <= '0;
                r_slot_cnt <= SLOT_CNT_W'(1);
                r_state    <= SHIFT;
              end
            end else if (w_lr_chg) begin
              sync_err_o  <= 1'b1;
              r_left_seen <= 1'b0;
              r_ch        <= w_lr;
              r_bit_cnt   <= '0;
              r_slot_cnt  <= SLOT_CNT_W'(1);
              r_state     <= SHIFT;
            end else begin
              r_shift    <= w_word[DATA_WIDTH-2:0];
              r_bit_cnt  <= r_bit_cnt + BIT_CNT_W'(1);
              r_slot_cnt <= w_slot_inc;
            end
          end
          PAD: begin
            if (w_lr_chg) begin
              r_ch       <= w_lr;
              r_bit_cnt  <= '0;
              r_slot_cnt <= SLOT_CNT_W'(1);
              r_state    <= SHIFT;
            end else begin
              r_slot_cnt <= w_slot_inc;
              if (w_slot_inc > SLOT_CNT_W'(SLOT_BITS)) begin
                sync_err_o  <= 1'b1;
                locked_o    <= 1'b0;
                r_left_seen <= 1'b0;
                r_state     <= HUNT;
              end
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives whole I2S slots and checks outputs against a slot-level model.
module tb_i2s_rx;

  localparam int unsigned DW   = 24;
  localparam int unsigned SB   = 32;
  localparam int unsigned SS   = 2;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          en    = 1'b1;
  logic          bclk  = 1'b0;
  logic          lrclk = 1'b0;
  logic          sdata = 1'b0;
  logic [DW-1:0] d_l;
  logic [DW-1:0] d_r;
  logic          valid;
  logic          locked;
  logic          sync_err;

  i2s_rx #(.DATA_WIDTH(DW), .SLOT_BITS(SB), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en),
    .bclk_i     (bclk),
    .lrclk_i    (lrclk),
    .sdata_i    (sdata),
    .d_l_o      (d_l),
    .d_r_o      (d_r),
    .valid_o    (valid),
    .locked_o   (locked),
    .sync_err_o (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } frame_t;

  int     n_vec   = 0;
  int     n_fail  = 0;
  int     cyc     = 0;
  logic   rst_q   = 1'b1;

  // slot-level model of the receiver
  frame_t        exp_q[$];
  logic          m_known      = 1'b0;
  logic          m_last       = 1'b0;
  logic          m_lseen      = 1'b0;
  logic          m_locked     = 1'b0;
  logic          m_pend_short = 1'b0;
  logic [DW-1:0] m_hold       = '0;
  int            m_err        = 0;

  // observations
  int            n_valid    = 0;
  int            n_err      = 0;
  int            lsb_cyc    = 0;
  logic [DW-1:0] hold_l     = '0;
  logic [DW-1:0] hold_r     = '0;
  logic          prev_valid = 1'b0;
  logic          prev_err   = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply one whole slot to the model: a slot opened by an LR change captures its word when
  // it carries the delay bit plus DATA_WIDTH bits, reports short at the next boundary otherwise,
  // and reports overrun when it lasts longer than SLOT_BITS.
  task automatic model_slot(input logic ch, input logic [DW-1:0] w, input int len,
                            input int rst_at, input logic en_v);
    logic   chg;
    frame_t f;
    chg = m_known && (ch != m_last);
    if (rst_at >= 0 || !en_v) begin
      m_lseen      = 1'b0;
      m_locked     = 1'b0;
      m_pend_short = 1'b0;
    end else if (chg) begin
      if (m_pend_short) begin
        m_err++;
        m_lseen = 1'b0;
      end
      m_pend_short = 1'b0;
      if (len > int'(DW)) begin
        if (ch == 1'b0) begin
          m_hold  = w;
          m_lseen = 1'b1;
        end else begin
          if (m_lseen) begin
            f.l = m_hold;
            f.r = w;
            exp_q.push_back(f);
            m_locked = 1'b1;
          end
          m_lseen = 1'b0;
        end
        if (len > int'(SB)) begin
          m_err++;
          m_locked = 1'b0;
          m_lseen  = 1'b0;
        end
      end else begin
        m_pend_short = 1'b1;
      end
    end
    m_known = 1'b1;
    m_last  = ch;
  endtask

  // One slot: data changes with bclk low, bclk high 4 clks; bit 0 is the I2S delay bit.
  task automatic send_slot(input logic ch, input logic [DW-1:0] w, input int len,
                           input int rst_at, input logic en_v);
    model_slot(ch, w, len, rst_at, en_v);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      bclk  = 1'b0;
      lrclk = ch;
      en    = en_v;
      sdata = (k >= 1 && k <= int'(DW)) ? w[int'(DW) - k] : 1'($urandom_range(0, 1));
      repeat (2) @(negedge clk);
      if (k == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        check("rst_d_l", d_l, 0);
        check("rst_d_r", d_r, 0);
        check("rst_valid", valid, 0);
        check("rst_locked", locked, 0);
        check("rst_sync_err", sync_err, 0);
        rst = 1'b0;
      end else begin
        @(negedge clk);
      end
      @(negedge clk);
      bclk = 1'b1;
      if (ch == 1'b1 && k == int'(DW)) lsb_cyc = cyc;
      repeat (3) @(negedge clk);
    end
    @(negedge clk);
    check("slot_locked", locked, m_locked);
    check("slot_err_count", n_err, m_err);
    check("slot_pending_valid", exp_q.size(), 0);
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic en_v);
    send_slot(1'b0, l, SB, -1, en_v);
    send_slot(1'b1, r, SB, -1, en_v);
  endtask

  // Per-cycle output checker against the model's expected frames.
  always @(negedge clk) begin : cmp
    frame_t e;
    if (rst_q) begin
      hold_l     = '0;
      hold_r     = '0;
      prev_valid = 1'b0;
      prev_err   = 1'b0;
    end else begin
      if (valid) begin
        n_valid++;
        check("valid_width", prev_valid, 0);
        check("valid_latency", cyc - lsb_cyc, SS + 2);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_valid: got d_l=0x%0h d_r=0x%0h with no frame expected", d_l, d_r);
          hold_l = d_l;
          hold_r = d_r;
        end else begin
          e = exp_q.pop_front();
          check("d_l", d_l, e.l);
          check("d_r", d_r, e.r);
          hold_l = e.l;
          hold_r = e.r;
        end
      end else begin
        check("hold_d_l", d_l, hold_l);
        check("hold_d_r", d_r, hold_r);
      end
      if (sync_err) begin
        n_err++;
        check("sync_err_width", prev_err, 0);
      end
      prev_valid = valid;
      prev_err   = sync_err;
    end
  end

  initial begin
    repeat (5) @(negedge clk);
    check("reset_d_l", d_l, 0);
    check("reset_d_r", d_r, 0);
    check("reset_valid", valid, 0);
    check("reset_locked", locked, 0);
    check("reset_sync_err", sync_err, 0);
    rst = 1'b0;

    // standard frames; the first left slot has no preceding LR change
    repeat (3) send_frame(24'hA5F00F, 24'h123456, 1'b1);
    check("p1_valids", n_valid, 2);
    check("p1_d_l", d_l, 24'hA5F00F);
    check("p1_d_r", d_r, 24'h123456);
    check("p1_locked", locked, 1);
    check("p1_errs", n_err, 0);

    // MSB/LSB placement
    send_frame(24'h800000, 24'h000001, 1'b1);
    check("p2_d_l_msb", d_l, 24'h800000);
    check("p2_d_r_lsb", d_r, 24'h000001);
    send_frame(24'h7FFFFF, 24'hFFFFFF, 1'b1);
    check("p2_valids", n_valid, 4);
    check("p2_d_l", d_l, 24'h7FFFFF);
    check("p2_d_r", d_r, 24'hFFFFFF);

    // short left slot
    send_slot(1'b0, 24'h111111, 10, -1, 1'b1);
    send_slot(1'b1, 24'h222222, SB, -1, 1'b1);
    check("p3_short_err", n_err, 1);
    check("p3_no_valid", n_valid, 4);
    send_frame(24'h13579B, 24'h2468AC, 1'b1);
    check("p3_valids", n_valid, 5);
    check("p3_d_l", d_l, 24'h13579B);

    // lrclk held for 40 bclks
    send_slot(1'b0, 24'h333333, 40, -1, 1'b1);
    check("p4_overrun_err", n_err, 2);
    check("p4_unlocked", locked, 0);
    send_slot(1'b1, 24'h444444, SB, -1, 1'b1);
    send_frame(24'hABCDEF, 24'hFEDCBA, 1'b1);
    check("p4_valids", n_valid, 6);
    check("p4_relocked", locked, 1);
    check("p4_d_r", d_r, 24'hFEDCBA);

    // reset during bit 12 of the right slot
    send_slot(1'b0, 24'h555555, SB, -1, 1'b1);
    send_slot(1'b1, 24'h666666, SB, 12, 1'b1);
    check("p5_no_valid", n_valid, 6);
    check("p5_d_l_cleared", d_l, 0);
    send_frame(24'hC0FFEE, 24'hBADA55, 1'b1);
    send_frame(24'h0F0F0F, 24'hF0F0F0, 1'b1);
    check("p5_valids", n_valid, 8);
    check("p5_d_l", d_l, 24'h0F0F0F);
    check("p5_d_r", d_r, 24'hF0F0F0);

    // receive disabled
    send_frame(24'h111AAA, 24'h222BBB, 1'b0);
    send_frame(24'h333CCC, 24'h444DDD, 1'b0);
    check("p6_no_valid", n_valid, 8);
    check("p6_unlocked", locked, 0);
    check("p6_hold_d_l", d_l, 24'h0F0F0F);
    check("p6_hold_d_r", d_r, 24'hF0F0F0);
    check("p6_errs", n_err, 2);
    send_frame(24'h5A5A5A, 24'hA5A5A5, 1'b1);
    send_frame(24'h5A5A5A, 24'hA5A5A5, 1'b1);
    check("p6_valids", n_valid, 10);
    check("p6_locked", locked, 1);
    check("p6_d_l", d_l, 24'h5A5A5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
